// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the round-robin adder scheduler.
package adder_sched_pkg;

  localparam int W        = 4;
  localparam int NREQ_MAX = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_rr_sched_rr_pick.sv
// Round-robin pick: first asserted request at or after rr_ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [IDW-1:0]  winner,
  output logic            any_req
);

  // The request with the smallest circular distance from rr_ptr wins.
  always_comb begin
    int off;
    int best_off;
    winner   = '0;
    any_req  = 1'b0;
    best_off = NREQ;
    off      = 0;
    for (int i = 0; i < NREQ; i++) begin
      off = (i >= int'(rr_ptr)) ? (i - int'(rr_ptr)) : (i + NREQ - int'(rr_ptr));
      if (req[i] && (off < best_off)) begin
        best_off = off;
        winner   = IDW'(i);
        any_req  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler time-sharing one external combinational adder
// between NREQ requesters: arbitrate, issue operands, capture result.
module adder_rr_sched #(
  parameter int NREQ = 4,
  parameter int W    = adder_sched_pkg::W,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  input  logic [W-1:0]      add_s,
  input  logic              add_cout,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              busy
);

  import adder_sched_pkg::*;

  state_e            state_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic [IDW-1:0]    id_q;
  logic [NREQ-1:0]   gnt_q;
  logic [W-1:0]      add_a_q;
  logic [W-1:0]      add_b_q;
  logic              rsp_valid_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [W-1:0]      rsp_sum_q;
  logic              rsp_cout_q;
  logic              busy_q;

  logic [IDW-1:0]    winner;
  logic              any_req;
  logic [W-1:0]      win_a_d;
  logic [W-1:0]      win_b_d;
  logic [NREQ-1:0]   win_oh_d;
  logic [IDW-1:0]    rr_ptr_d;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // Select the winner's operand pair and one-hot grant; advance pointer past the winner.
  always_comb begin
    win_a_d  = '0;
    win_b_d  = '0;
    win_oh_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        win_a_d     = req_a[i*W +: W];
        win_b_d     = req_b[i*W +: W];
        win_oh_d[i] = 1'b1;
      end
    end
    rr_ptr_d = (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
  end

  // Scheduler FSM: IDLE/CAPTURE arbitrate, ISSUE lets the adder settle, then capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        ISSUE: begin
          rsp_sum_q   <= add_s;
          rsp_cout_q  <= add_cout;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= CAPTURE;
          busy_q      <= 1'b1;
        end
        IDLE, CAPTURE: begin
          if (any_req) begin
            add_a_q  <= win_a_d;
            add_b_q  <= win_b_d;
            gnt_q    <= win_oh_d;
            id_q     <= winner;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= ISSUE;
            busy_q   <= 1'b1;
          end else begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adder_rr_sched.sv
// Directed bench for adder_rr_sched; the bench also plays the external 4-bit adder.
module tb_adder_rr_sched;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic [W-1:0]      add_s;
  logic              add_cout;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic              busy;

  int n_chk;
  int n_fail;

  adder_rr_sched #(
    .NREQ (NREQ),
    .W    (W),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .gnt       (gnt),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  // Stand-in for the external combinational adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  logic [NREQ-1:0] fair_gnt [10];
  logic [IDW-1:0]  fair_id  [10];
  logic [W-1:0]    fair_sum [10];
  logic            fair_co  [10];
  int              pulses;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    req    = '0;
    req_a  = '0;
    req_b  = '0;

    // 1. reset held with all requests active
    rst = 1'b1;
    req = 4'b1111;
    set_lane(0, 4'd5, 4'd6);
    set_lane(1, 4'd7, 4'd3);
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    chk("rst_add_b", 32'(add_b), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    rst = 1'b0;
    req = '0;
    tick();
    chk("idle_gnt", 32'(gnt), 32'd0);

    // 2. single request on lane 0: 1+1
    set_lane(0, 4'd1, 4'd1);
    req = 4'b0001;
    tick();
    chk("t2_gnt", 32'(gnt), 32'b0001);
    chk("t2_gnt_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t2_add_a", 32'(add_a), 32'd1);
    chk("t2_busy", 32'(busy), 32'd1);
    req = '0;
    tick();
    chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t2_rsp_gnt", 32'(gnt), 32'd0);
    chk("t2_rsp_id", 32'(rsp_id), 32'd0);
    chk("t2_rsp_sum", 32'(rsp_sum), 32'd2);
    chk("t2_rsp_cout", 32'(rsp_cout), 32'd0);
    tick();
    chk("t2_done_valid", 32'(rsp_valid), 32'd0);
    chk("t2_done_busy", 32'(busy), 32'd0);

    // 3. overflow on lane 2: 15+15 = 30 -> sum 14, carry 1
    set_lane(2, 4'd15, 4'd15);
    req = 4'b0100;
    tick();
    chk("t3_gnt", 32'(gnt), 32'b0100);
    req = '0;
    tick();
    chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t3_rsp_id", 32'(rsp_id), 32'd2);
    chk("t3_rsp_sum", 32'(rsp_sum), 32'd14);
    chk("t3_rsp_cout", 32'(rsp_cout), 32'd1);
    tick();

    // 5. rr_ptr now 3: req 0101 -> lane 0 (0+0) first, then lane 2 (7+9 = 16)
    set_lane(0, 4'd0, 4'd0);
    set_lane(2, 4'd7, 4'd9);
    req = 4'b0101;
    tick();
    chk("t5_gnt0", 32'(gnt), 32'b0001);
    req = 4'b0100;
    tick();
    chk("t5_rsp0_valid", 32'(rsp_valid), 32'd1);
    chk("t5_rsp0_id", 32'(rsp_id), 32'd0);
    chk("t5_rsp0_sum", 32'(rsp_sum), 32'd0);
    chk("t5_rsp0_cout", 32'(rsp_cout), 32'd0);
    tick();
    chk("t5_gnt2", 32'(gnt), 32'b0100);
    chk("t5_gnt2_rsp_valid", 32'(rsp_valid), 32'd0);
    req = '0;
    tick();
    chk("t5_rsp2_id", 32'(rsp_id), 32'd2);
    chk("t5_rsp2_sum", 32'(rsp_sum), 32'd0);
    chk("t5_rsp2_cout", 32'(rsp_cout), 32'd1);
    tick();
    chk("t5_idle_busy", 32'(busy), 32'd0);

    // 6. reset during ISSUE drops the operation
    set_lane(1, 4'd3, 4'd4);
    set_lane(3, 4'd9, 4'd4);
    req = 4'b0010;
    tick();
    chk("t6_gnt", 32'(gnt), 32'b0010);
    rst = 1'b1;
    req = 4'b1010;
    tick();
    chk("t6_rst_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rst_gnt", 32'(gnt), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_add_a", 32'(add_a), 32'd0);
    rst = 1'b0;
    tick();
    chk("t6_post_gnt", 32'(gnt), 32'b0010);
    chk("t6_post_valid", 32'(rsp_valid), 32'd0);
    req = 4'b1000;
    tick();
    chk("t6_rsp1_valid", 32'(rsp_valid), 32'd1);
    chk("t6_rsp1_id", 32'(rsp_id), 32'd1);
    chk("t6_rsp1_sum", 32'(rsp_sum), 32'd7);
    tick();
    chk("t6_gnt3", 32'(gnt), 32'b1000);
    req = '0;
    tick();
    chk("t6_rsp3_id", 32'(rsp_id), 32'd3);
    chk("t6_rsp3_sum", 32'(rsp_sum), 32'd13);
    chk("t6_rsp3_cout", 32'(rsp_cout), 32'd0);
    tick();

    // 4. fairness from rr_ptr=0 (wrapped after lane 3): all lanes held active
    set_lane(0, 4'd1,  4'd2);
    set_lane(1, 4'd5,  4'd6);
    set_lane(2, 4'd12, 4'd5);
    set_lane(3, 4'd8,  4'd8);
    fair_gnt = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    fair_id  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
    fair_sum = '{4'd0, 4'd3, 4'd0, 4'd11, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd3};
    fair_co  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    pulses = 0;
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("t4_gnt_c%0d", c), 32'(gnt), 32'(fair_gnt[c]));
      chk($sformatf("t4_excl_c%0d", c), 32'((gnt != '0) && rsp_valid), 32'd0);
      if (rsp_valid) pulses++;
      if ((c % 2) == 1) begin
        chk($sformatf("t4_valid_c%0d", c), 32'(rsp_valid), 32'd1);
        chk($sformatf("t4_id_c%0d", c), 32'(rsp_id), 32'(fair_id[c]));
        chk($sformatf("t4_sum_c%0d", c), 32'(rsp_sum), 32'(fair_sum[c]));
        chk($sformatf("t4_cout_c%0d", c), 32'(rsp_cout), 32'(fair_co[c]));
      end
      if (c == 9) req = '0;
    end
    chk("t4_pulses", 32'(pulses), 32'd5);
    tick();
    chk("t4_end_valid", 32'(rsp_valid), 32'd0);
    chk("t4_end_gnt", 32'(gnt), 32'd0);
    chk("t4_end_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
